// File: rtl/fir_decim_pkg.sv
// rtl/fir_decim_pkg.sv - shared constants and width/scaling helpers for the FIR decimating output stage
package fir_decim_pkg;

    localparam int FIR_OUT_W = 16;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Accumulator must hold DECIM full-scale samples without wrapping
    function automatic int acc_width(input int decim);
        return FIR_OUT_W + clog2(decim);
    endfunction

    // Total right shift: divide by DECIM plus the FIR gain compensation
    function automatic int shift_amount(input int decim, input int gain_shift);
        return clog2(decim) + gain_shift;
    endfunction

    function automatic logic signed [31:0] saturate(input logic signed [31:0] value, input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/fir_decim_out_if.sv
// rtl/fir_decim_out_if.sv - sample input and decimated output handshake bundle
interface fir_decim_out_if #(
    parameter int OUT_W = 8
);
    logic                                    in_valid;
    logic signed [fir_decim_pkg::FIR_OUT_W-1:0] in_data;
    logic                                    out_valid;
    logic                                    out_ready;
    logic signed [OUT_W-1:0]                 out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/fir_decim_fifo.sv
// rtl/fir_decim_fifo.sv - synchronous FIFO with occupancy count and registered-pointer head output
module fir_decim_fifo
    import fir_decim_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  level
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_level == '0);
    assign full      = (r_level == FULL_LVL);
    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];
    assign level     = r_level;

    // Storage write; pointers alone define validity so the array needs no reset
    always_ff @(posedge clk) begin
        if (w_do_push && !clr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fir_decim_out.sv
// rtl/fir_decim_out.sv - integrate-and-dump decimator with round/saturate and output FIFO (option: SAT_COUNT_EN)
module fir_decim_out
    import fir_decim_pkg::*;
#(
    parameter int DECIM      = 4,
    parameter int GAIN_SHIFT = 3,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    fir_decim_out_if.slave              bus,
    output logic [clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                        overflow
`ifdef SAT_COUNT_EN
    ,
    output logic [15:0]                 sat_count
`endif
);
    localparam int ACC_W = acc_width(DECIM);
    localparam int S     = shift_amount(DECIM, GAIN_SHIFT);
    localparam int LOG_D = clog2(DECIM);
    localparam int PH_W  = (LOG_D > 0) ? LOG_D : 1;
    // Half an output LSB, so the arithmetic shift rounds half toward +inf; zero when S is zero
    localparam logic signed [31:0] ROUND_ADD = (32'sd1 <<< S) >>> 1;

    logic [PH_W-1:0]         r_phase;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_pipe_valid;
    logic signed [OUT_W-1:0] r_pipe_data;
    logic                    r_overflow;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [31:0]      w_sum32;
    logic signed [31:0]      w_round;
    logic                    w_last;
    logic                    w_full;
    logic                    w_empty;
    logic [OUT_W-1:0]        w_fifo_dout;

    assign w_sum   = r_acc + ACC_W'($signed(bus.in_data));
    assign w_sum32 = 32'(w_sum);
    assign w_round = (w_sum32 + ROUND_ADD) >>> S;
    assign w_last  = (r_phase == PH_W'(DECIM - 1));

    // Integrate samples; the completed frame's scaled, clamped result lands in the pipe register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase      <= '0;
            r_acc        <= '0;
            r_pipe_valid <= 1'b0;
            r_pipe_data  <= '0;
        end else if (clr) begin
            r_phase      <= '0;
            r_acc        <= '0;
            r_pipe_valid <= 1'b0;
            r_pipe_data  <= '0;
        end else begin
            r_pipe_valid <= 1'b0;
            if (bus.in_valid) begin
                if (w_last) begin
                    r_acc        <= '0;
                    r_phase      <= '0;
                    r_pipe_valid <= 1'b1;
                    r_pipe_data  <= OUT_W'(saturate(w_round, OUT_W));
                end else begin
                    r_acc   <= w_sum;
                    r_phase <= r_phase + PH_W'(1);
                end
            end
        end
    end

    // Sticky flag for a result lost to a full FIFO with no concurrent pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_overflow <= 1'b0;
        end else if (r_pipe_valid && w_full && !bus.out_ready) begin
            r_overflow <= 1'b1;
        end
    end

    fir_decim_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (r_pipe_valid),
        .pop   (bus.out_ready),
        .din   (r_pipe_data),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_fifo_dout;
    assign overflow      = r_overflow;

`ifdef SAT_COUNT_EN
    logic [15:0] r_sat_count;
    logic        w_clamped;

    assign w_clamped = (saturate(w_round, OUT_W) != w_round);

    // Count clamped results when they are produced, whether or not the FIFO later keeps them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (clr) begin
            r_sat_count <= '0;
        end else if (bus.in_valid && w_last && w_clamped && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count = r_sat_count;
`endif

endmodule

// File: tb/tb_fir_decim_out.sv
// tb/tb_fir_decim_out.sv - scoreboard bench for fir_decim_out against a frame-average queue model
module tb_fir_decim_out;
    localparam int DECIM      = 4;
    localparam int GAIN_SHIFT = 3;
    localparam int OUT_W      = 8;
    localparam int FIFO_DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [3:0] fifo_level;
    logic       overflow;
`ifdef SAT_COUNT_EN
    logic [15:0] sat_count;
`endif

    fir_decim_out_if #(.OUT_W(OUT_W)) bus();

    fir_decim_out #(
        .DECIM      (DECIM),
        .GAIN_SHIFT (GAIN_SHIFT),
        .OUT_W      (OUT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .bus        (bus),
        .fifo_level (fifo_level),
        .overflow   (overflow)
`ifdef SAT_COUNT_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_pops = 0;

    int frame_q[$];
    int exp_q[$];
    int m_level = 0;
    int m_ovf = 0;
    int m_sat = 0;
    int pend_valid = 0;
    int pend_val = 0;

    // Average of a frame scaled by 2^-GAIN_SHIFT, rounded half up (floor of x + 1/2)
    function automatic int ref_unclamped(input int sum);
        int scale;
        int t;
        int q;
        scale = DECIM << GAIN_SHIFT;
        t = sum + scale / 2;
        q = t / scale;
        if ((t % scale) != 0 && t < 0) q = q - 1;
        return q;
    endfunction

    function automatic int ref_clamp(input int v);
        int hi;
        int lo;
        hi = (1 << (OUT_W - 1)) - 1;
        lo = -(1 << (OUT_W - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames of DECIM accepted samples, one-cycle pipe, FIFO occupancy by count
    initial begin : model
        int sum;
        int u;
        int c;
        forever begin
            @(posedge clk or posedge rst);
            if (rst || clr) begin
                frame_q.delete();
                exp_q.delete();
                m_level = 0;
                m_ovf = 0;
                m_sat = 0;
                pend_valid = 0;
            end else begin
                if (m_level > 0 && bus.out_ready) m_level = m_level - 1;
                if (pend_valid != 0) begin
                    if (m_level < FIFO_DEPTH) begin
                        exp_q.push_back(pend_val);
                        m_level = m_level + 1;
                    end else begin
                        m_ovf = 1;
                    end
                    pend_valid = 0;
                end
                if (bus.in_valid) begin
                    frame_q.push_back(int'(bus.in_data));
                    if (frame_q.size() == DECIM) begin
                        sum = 0;
                        foreach (frame_q[i]) sum = sum + frame_q[i];
                        u = ref_unclamped(sum);
                        c = ref_clamp(u);
                        if (c != u && m_sat < 65535) m_sat = m_sat + 1;
                        pend_val = c;
                        pend_valid = 1;
                        frame_q.delete();
                    end
                end
            end
        end
    end

    // Monitor: compare status every cycle and pop the scoreboard on each handshake
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("out_valid", int'(bus.out_valid), (m_level != 0) ? 1 : 0);
                chk("fifo_level", int'(fifo_level), m_level);
                chk("overflow", int'(overflow), m_ovf);
`ifdef SAT_COUNT_EN
                chk("sat_count", int'(sat_count), m_sat);
`endif
                if (bus.out_valid && bus.out_ready && !clr) begin
                    n_pops = n_pops + 1;
                    if (exp_q.size() == 0) begin
                        n_vec = n_vec + 1;
                        n_err = n_err + 1;
                        $display("FAIL out_data: got %0d with no expected entry at %0t", int'(bus.out_data), $time);
                    end else begin
                        chk("out_data", int'(bus.out_data), exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input int v);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'(v);
        cyc(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic frame(input int v);
        repeat (DECIM) sample(v);
    endtask

    int rnd_in[6]  = '{4, 3, -4, -5, 32767, -32768};
    int rnd_exp[6] = '{1, 0, 0, -1, 127, -128};

    initial begin : stim
        int p0;
        int v;
        rst = 1'b1;
        clr = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        cyc(3);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_fifo_level", int'(fifo_level), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst = 1'b0;
        cyc(1);

        // Basic average and two-cycle latency
        frame(100);
        chk("lat_n1_out_valid", int'(bus.out_valid), 0);
        cyc(1);
        chk("lat_n2_out_valid", int'(bus.out_valid), 1);
        chk("basic_out_data", int'(bus.out_data), 13);
        chk("basic_level", int'(fifo_level), 1);
        bus.out_ready = 1'b1;
        cyc(2);
        bus.out_ready = 1'b0;

        // Rounding and saturation table
        for (int i = 0; i < 6; i++) begin
            frame(rnd_in[i]);
            cyc(1);
            chk("round_sat_out_data", int'(bus.out_data), rnd_exp[i]);
            bus.out_ready = 1'b1;
            cyc(1);
            bus.out_ready = 1'b0;
        end
`ifdef SAT_COUNT_EN
        chk("sat_count_two", int'(sat_count), 2);
`endif

        // Overflow: nine frames into an eight-entry FIFO with no consumer
        repeat (9) frame(32);
        cyc(2);
        chk("ovf_level", int'(fifo_level), 8);
        chk("ovf_flag", int'(overflow), 1);
        p0 = n_pops;
        bus.out_ready = 1'b1;
        cyc(12);
        bus.out_ready = 1'b0;
        chk("ovf_drain_count", n_pops - p0, 8);
        chk("ovf_drain_valid", int'(bus.out_valid), 0);
        chk("ovf_sticky", int'(overflow), 1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("clr_overflow", int'(overflow), 0);
        chk("clr_level", int'(fifo_level), 0);

        // Full FIFO with a pop in the push cycle
        repeat (8) frame(32);
        cyc(2);
        chk("full_level", int'(fifo_level), 8);
        frame(32);
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
        chk("full_pop_level", int'(fifo_level), 8);
        chk("full_pop_overflow", int'(overflow), 0);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;

        // Reset discards a partial frame
        sample(1000);
        sample(1000);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        frame(64);
        cyc(1);
        chk("rst_mid_out_data", int'(bus.out_data), 8);
        chk("rst_mid_level", int'(fifo_level), 1);
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;

        // Gaps inside a frame do not disturb the sum
        sample(64);
        sample(64);
        cyc(2);
        sample(64);
        sample(64);
        cyc(1);
        chk("gap_out_data", int'(bus.out_data), 8);
        bus.out_ready = 1'b1;
        cyc(1);

        // Randomised traffic with stalls and occasional flushes
        for (int k = 0; k < 600; k++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 400)) - 200;
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_data   = 16'(v);
            bus.out_ready = (k % 100 < 60) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            clr           = ($urandom_range(0, 149) == 0);
            cyc(1);
        end
        bus.in_valid  = 1'b0;
        clr           = 1'b0;
        bus.out_ready = 1'b1;
        cyc(20);
        chk("final_level", int'(fifo_level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
Output stage directly downstream of the FIR filter. It consumes the 16-bit signed filter output stream and decimates it by DECIM using integrate-and-dump averaging. Each average is rescaled with rounding and saturation to an OUT_W-bit signed sample, then buffered in a small FIFO. The FIFO is drained through a valid/ready interface toward the DAC/serializer side.

Parameters:
DECIM, 4, decimation ratio; power of two, 1..16
GAIN_SHIFT, 3, extra arithmetic right shift compensating FIR coefficient gain; 0..8
OUT_W, 8, output sample width (signed)
FIFO_DEPTH, 8, output FIFO entries; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  in_data holds a new filter sample this cycle
in_data  in  16  signed filter output sample
clr  in  1  synchronous flush: phase, accumulator, pipe register, FIFO, overflow
out_valid  out  1  FIFO non-empty; out_data valid
out_ready  in  1  consumer accepts out_data this cycle
out_data  out  OUT_W  signed decimated sample (FIFO head)
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky; a result was dropped because the FIFO was full

Behaviour:
- Reset (rst=1, async): phase=0, acc=0, pipe_valid=0, FIFO empty, out_valid=0, out_data=0, fifo_level=0, overflow=0. Any partial frame is discarded.
- Widths: ACC_W = 16 + log2(DECIM); S = log2(DECIM) + GAIN_SHIFT.
- Accumulation: on each cycle with in_valid=1, acc += sign-extended in_data and phase increments.
  - On the sample where phase==DECIM-1, the final sum (acc + in_data) goes to the pipe stage, acc reloads to 0, and phase wraps to 0.
  - in_valid=0 holds phase and acc; gaps are allowed.
- Pipe stage (1 cycle):
  - If S>0: r = (sum + 2^(S-1)) >>> S, i.e. round half toward +inf. If S=0: r = sum.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and register it with pipe_valid=1.
- FIFO push: in the cycle pipe_valid=1.
  - Full and no pop that cycle: the result is dropped and overflow is set.
  - Full with simultaneous pop: the push is accepted and overflow is not set.
- Latency: last sample of a frame accepted in cycle N -> pipe register in N+1 -> out_valid=1 in N+2 if the FIFO was empty. There is no bypass.
- Pop: out_valid && out_ready. out_data shows the next entry the following cycle. out_ready while empty is ignored.
- Push and pop in the same cycle: fifo_level unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- clr=1: same effect as reset, taking effect at the clock edge. clr has priority over in_valid, push and pop in that cycle.
- overflow clears only on rst or clr.
- Output stability: out_data and out_valid must not change while out_valid=1 and out_ready=0, except on clr or rst.

Optional Feature:
SAT_COUNT_EN
- Defined: adds output port sat_count (16 bits). It counts results clamped by saturation, including dropped ones, stops at 16'hFFFF, and clears on rst or clr.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package fir_decim_pkg:
  - clog2 function
  - FIR_OUT_W=16 constant
  - derived-width helper functions for ACC_W and S
  - saturate function
- Sub-module: fir_decim_fifo, a synchronous FIFO parameterised by width and depth, with push/pop/full/empty/level. The accumulator, phase counter and pipe stage stay in the top module.

Test Plan:
(All rows use defaults DECIM=4, GAIN_SHIFT=3, so S=5.)
- Four in_valid samples of 100 -> one out_data=13, out_valid rising 2 cycles after the 4th sample; fifo_level=1.
- Four samples of 16'sh7FFF -> out_data=127 (saturated). Four samples of 16'sh8000 -> out_data=-128. With SAT_COUNT_EN, sat_count=2.
- Rounding: four samples of 4 -> 1; four of 3 -> 0; four of -4 -> 0; four of -5 -> -1.
- out_ready=0, 9 frames of constant 32 (result 4 each) -> fifo_level=8, overflow=1 after the 9th. Then hold out_ready=1 -> exactly 8 outputs of 4, then out_valid=0.
- FIFO full, out_ready=1 in the same cycle as a push -> level stays 8 and overflow stays 0.
- Assert rst mid-frame after 2 samples, then 4 samples of 64 -> out_data=8. A 2-cycle in_valid gap inside a frame gives the same result.
